// File: rtl/asic_latch_pkg.sv
// Shared types and helpers for the latch-based register file and its clock primitives.
package asic_latch_pkg;

  localparam int STD_TECHNOLOGY_ASIC_TSMC = 0;
  localparam int STD_TECHNOLOGY_FPGA      = 1;

  typedef enum logic {
    ASIC_LATCH_CLEAR = 1'b0,
    ASIC_LATCH_READY = 1'b1
  } asic_latch_state_e;

  function automatic int asic_latch_lanes(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

endpackage

// File: rtl/asic_latch_clear_fsm.sv
// Post-reset zero-fill sequencer: walks every entry once, then opens the array for writes.
module asic_latch_clear_fsm
  import asic_latch_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  ready_o,
  output logic                  clear_o,
  output logic [ADDR_WIDTH-1:0] clear_addr_o
);

  localparam asic_latch_state_e RESET_STATE =
    (CLEAR_ON_RESET != 0) ? ASIC_LATCH_CLEAR : ASIC_LATCH_READY;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  asic_latch_state_e     state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Extra counter bit: the MSB marks "all entries done" at any depth without aliasing entry 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ASIC_LATCH_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_d[ADDR_WIDTH]) state_d = ASIC_LATCH_READY;
      end
      ASIC_LATCH_READY: state_d = ASIC_LATCH_READY;
      default:          state_d = RESET_STATE;
    endcase
  end

  assign ready_o      = (state_q == ASIC_LATCH_READY);
  assign clear_o      = (state_q == ASIC_LATCH_CLEAR);
  assign clear_addr_o = cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/std_clock_gate.sv
// Glitch-free clock gate: enable is frozen while the clock is high so gclk_o only ever shortens to whole pulses.
module std_clock_gate
  import asic_latch_pkg::*;
#(
  parameter logic [0:0] CLOCK_INFO = 'b0,
  parameter int         TECHNOLOGY = STD_TECHNOLOGY_ASIC_TSMC
) (
  input  logic clk_i,
  input  logic en_i,
  output logic gclk_o
);

  logic clk_c;
  assign clk_c = clk_i ^ CLOCK_INFO[0];

  if (TECHNOLOGY == STD_TECHNOLOGY_FPGA) begin : g_fpga
    // Emulation targets sample the enable with a falling-edge flop instead of a latch.
    logic en_q;
    always_ff @(negedge clk_c) en_q <= en_i;
    assign gclk_o = clk_c & en_q;
  end else begin : g_asic
    logic en_q;
    always_latch begin
      if (!clk_c) en_q <= en_i;
    end
    assign gclk_o = clk_c & en_q;
  end

endmodule

// File: rtl/std_register.sv
// Generic enabled register with asynchronous active-low reset; CLOCK_INFO[0] selects falling-edge capture.
module std_register #(
  parameter logic [0:0]       CLOCK_INFO  = 'b0,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  if (CLOCK_INFO[0]) begin : g_neg
    always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= RESET_VALUE;
      else if (en_i) q_q <= d_i;
    end
  end else begin : g_pos
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= RESET_VALUE;
      else if (en_i) q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/asic_latch_regfile.sv
// Multi-port latch register file: writes are flopped at the edge and land in per-lane latches during the next high phase.
module asic_latch_regfile
  import asic_latch_pkg::*;
#(
  parameter logic [0:0] CLOCK_INFO     = 'b0,
  parameter int         TECHNOLOGY     = STD_TECHNOLOGY_ASIC_TSMC,
  parameter int         DATA_WIDTH     = 32,
  parameter int         LANE_WIDTH     = 8,
  parameter int         ADDR_WIDTH     = 5,
  parameter int         READ_PORTS     = 2,
  parameter int         WRITE_PORTS    = 2,
  parameter int         BYPASS         = 1,
  parameter int         CLEAR_ON_RESET = 1
) (
  input  logic                                                            clk,
  input  logic                                                            rst,
  input  logic [WRITE_PORTS-1:0]                                          write_enable,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0]                               write_addr,
  input  logic [WRITE_PORTS*asic_latch_lanes(DATA_WIDTH, LANE_WIDTH)-1:0] write_mask,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]                               write_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]                                read_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]                                read_data,
  output logic                                                            ready
);

  localparam int LANES = asic_latch_lanes(DATA_WIDTH, LANE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                            clear_active;
  logic [ADDR_WIDTH-1:0]           clear_addr;
  logic                            clr_vld_q;
  logic [ADDR_WIDTH-1:0]           clr_addr_q;
  logic [WRITE_PORTS-1:0]          wvld_q;
  logic [WRITE_PORTS*ADDR_WIDTH-1:0] waddr_q;
  logic [WRITE_PORTS*LANES-1:0]    wmask_q;
  logic [WRITE_PORTS*DATA_WIDTH-1:0] wdata_q;
  logic [DEPTH-1:0][LANES-1:0]     gate_en;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] lane_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  asic_latch_clear_fsm #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk_i       (clk),
    .rst_ni      (rst),
    .ready_o     (ready),
    .clear_o     (clear_active),
    .clear_addr_o(clear_addr)
  );

  for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_wport
    std_register #(.CLOCK_INFO(CLOCK_INFO), .WIDTH(1)) u_wvld (
      .clk_i (clk),
      .rst_ni(rst),
      .en_i  (1'b1),
      .d_i   (write_enable[p] & ready),
      .q_o   (wvld_q[p])
    );
    std_register #(.CLOCK_INFO(CLOCK_INFO), .WIDTH(ADDR_WIDTH + LANES + DATA_WIDTH)) u_wreg (
      .clk_i (clk),
      .rst_ni(rst),
      .en_i  (write_enable[p]),
      .d_i   ({write_addr[p*ADDR_WIDTH +: ADDR_WIDTH], write_mask[p*LANES +: LANES],
               write_data[p*DATA_WIDTH +: DATA_WIDTH]}),
      .q_o   ({waddr_q[p*ADDR_WIDTH +: ADDR_WIDTH], wmask_q[p*LANES +: LANES],
               wdata_q[p*DATA_WIDTH +: DATA_WIDTH]})
    );
  end

  std_register #(.CLOCK_INFO(CLOCK_INFO), .WIDTH(ADDR_WIDTH + 1)) u_clr_reg (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (1'b1),
    .d_i   ({clear_active, clear_addr}),
    .q_o   ({clr_vld_q, clr_addr_q})
  );

  // Gate enables come from the live request so the gated pulse is the high phase right after the capturing edge.
  always_comb begin
    gate_en = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int l = 0; l < LANES; l++) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (write_enable[p] && ready && write_mask[p*LANES + l] &&
              write_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e))
            gate_en[e][l] = 1'b1;
        end
        if (clear_active && clear_addr == ADDR_WIDTH'(e)) gate_en[e][l] = 1'b1;
      end
    end
  end

  // Latch input: the zero default doubles as clear data; higher ports overwrite lower ones lane by lane.
  always_comb begin
    lane_d = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int l = 0; l < LANES; l++) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (wvld_q[p] && wmask_q[p*LANES + l] &&
              waddr_q[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e) &&
              !(clr_vld_q && clr_addr_q == ADDR_WIDTH'(e)))
            lane_d[e][l*LANE_WIDTH +: LANE_WIDTH] = wdata_q[p*DATA_WIDTH + l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic                  gclk;
      logic [LANE_WIDTH-1:0] lane_q;

      std_clock_gate #(.CLOCK_INFO(CLOCK_INFO), .TECHNOLOGY(TECHNOLOGY)) u_cg (
        .clk_i (clk),
        .en_i  (gate_en[e][l]),
        .gclk_o(gclk)
      );

      always_latch begin
        if (gclk) lane_q <= lane_d[e][l*LANE_WIDTH +: LANE_WIDTH];
      end

      assign mem[e][l*LANE_WIDTH +: LANE_WIDTH] = lane_q;
    end
  end

  always_comb begin
    read_data = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      read_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[read_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS != 0 && ready) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          for (int l = 0; l < LANES; l++) begin
            if (write_enable[p] && write_mask[p*LANES + l] &&
                write_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == read_addr[r*ADDR_WIDTH +: ADDR_WIDTH])
              read_data[r*DATA_WIDTH + l*LANE_WIDTH +: LANE_WIDTH] =
                write_data[p*DATA_WIDTH + l*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_asic_latch_regfile.sv
// Directed bench for asic_latch_regfile: 16-entry, 2R/2W, byte lanes, bypass and clear-on-reset enabled.
module tb_asic_latch_regfile;
  import asic_latch_pkg::*;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int AW = 4;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam int LN = DW / LW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WP-1:0]     write_enable = '0;
  logic [WP*AW-1:0]  write_addr   = '0;
  logic [WP*LN-1:0]  write_mask   = '0;
  logic [WP*DW-1:0]  write_data   = '0;
  logic [RP*AW-1:0]  read_addr    = '0;
  logic [RP*DW-1:0]  read_data;
  logic              ready;

  int n_checks = 0;
  int n_errors = 0;

  asic_latch_regfile #(
    .CLOCK_INFO    ('b0),
    .TECHNOLOGY    (STD_TECHNOLOGY_ASIC_TSMC),
    .DATA_WIDTH    (DW),
    .LANE_WIDTH    (LW),
    .ADDR_WIDTH    (AW),
    .READ_PORTS    (RP),
    .WRITE_PORTS   (WP),
    .BYPASS        (1),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_mask  (write_mask),
    .write_data  (write_data),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [LN-1:0] m, input logic [DW-1:0] d);
    write_enable[p]        = 1'b1;
    write_addr[p*AW +: AW] = a;
    write_mask[p*LN +: LN] = m;
    write_data[p*DW +: DW] = d;
  endtask

  task automatic clr_wr();
    write_enable = '0;
    write_mask   = '0;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    read_addr[r*AW +: AW] = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr_wr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin n_errors++; $display("FAIL clear_ready cycle %0d: got %b expected 0", i, ready); end
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin n_errors++; $display("FAIL ready_after_clear: got %b expected 1", ready); end
    for (int a = 0; a < 16; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(15 - a));
      #1;
      n_checks++;
      if (read_data !== 64'h0) begin n_errors++; $display("FAIL cleared_read addr %0d: got %h expected 0", a, read_data); end
    end
  endtask

  task automatic test_write_mask();
    set_wr(0, 4'd3, 4'hF, 32'hDEADBEEF);
    set_rd(0, 4'd3);
    set_rd(1, 4'd3);
    next_cycle();
    clr_wr();
    @(negedge clk);
    n_checks++;
    if (read_data[31:0] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL full_write: got %h expected deadbeef", read_data[31:0]); end
    set_wr(1, 4'd3, 4'h5, 32'h11223344);
    next_cycle();
    clr_wr();
    @(negedge clk);
    n_checks++;
    if (read_data !== {32'hDE22BE44, 32'hDE22BE44}) begin n_errors++; $display("FAIL masked_write: got %h expected de22be44de22be44", read_data); end
  endtask

  task automatic test_same_entry();
    set_wr(0, 4'd7, 4'hF, 32'hAAAAAAAA);
    set_wr(1, 4'd7, 4'h3, 32'h55555555);
    set_rd(0, 4'd7);
    set_rd(1, 4'd0);
    next_cycle();
    clr_wr();
    @(negedge clk);
    n_checks++;
    if (read_data[31:0] !== 32'hAAAA5555) begin n_errors++; $display("FAIL port_priority: got %h expected aaaa5555", read_data[31:0]); end
  endtask

  task automatic test_bypass();
    set_wr(0, 4'd9, 4'hF, 32'h12345678);
    set_wr(1, 4'd3, 4'h2, 32'hFFFFAAFF);
    set_rd(0, 4'd9);
    set_rd(1, 4'd3);
    #1;
    n_checks++;
    if (read_data[31:0] !== 32'h12345678) begin n_errors++; $display("FAIL bypass_full: got %h expected 12345678", read_data[31:0]); end
    n_checks++;
    if (read_data[63:32] !== 32'hDE22AA44) begin n_errors++; $display("FAIL bypass_partial: got %h expected de22aa44", read_data[63:32]); end
    next_cycle();
    clr_wr();
    @(negedge clk);
    n_checks++;
    if (read_data !== {32'hDE22AA44, 32'h12345678}) begin n_errors++; $display("FAIL bypass_stored: got %h expected de22aa4412345678", read_data); end
    set_wr(0, 4'd12, 4'hF, 32'h01020304);
    set_wr(1, 4'd12, 4'hC, 32'hA0B0C0D0);
    set_rd(0, 4'd12);
    set_rd(1, 4'd12);
    #1;
    n_checks++;
    if (read_data[31:0] !== 32'hA0B00304) begin n_errors++; $display("FAIL bypass_priority: got %h expected a0b00304", read_data[31:0]); end
    next_cycle();
    clr_wr();
    @(negedge clk);
    n_checks++;
    if (read_data !== {32'hA0B00304, 32'hA0B00304}) begin n_errors++; $display("FAIL priority_stored: got %h expected a0b00304a0b00304", read_data); end
  endtask

  task automatic test_zero_mask();
    set_wr(0, 4'd3, 4'h0, 32'h00000000);
    set_wr(1, 4'd7, 4'hF, 32'h00000000);
    write_enable[1] = 1'b0;
    set_rd(0, 4'd3);
    set_rd(1, 4'd7);
    #1;
    n_checks++;
    if (read_data !== {32'hAAAA5555, 32'hDE22AA44}) begin n_errors++; $display("FAIL zero_mask_bypass: got %h expected aaaa5555de22aa44", read_data); end
    next_cycle();
    clr_wr();
    @(negedge clk);
    n_checks++;
    if (read_data !== {32'hAAAA5555, 32'hDE22AA44}) begin n_errors++; $display("FAIL zero_mask_hold: got %h expected aaaa5555de22aa44", read_data); end
  endtask

  task automatic test_back_to_back();
    set_wr(0, 4'd1, 4'hF, 32'h11111111);
    set_rd(0, 4'd1);
    set_rd(1, 4'd2);
    next_cycle();
    clr_wr();
    set_wr(0, 4'd2, 4'hF, 32'h22222222);
    @(negedge clk);
    n_checks++;
    if (read_data !== {32'h22222222, 32'h11111111}) begin n_errors++; $display("FAIL b2b_first: got %h expected 2222222211111111", read_data); end
    next_cycle();
    clr_wr();
    set_wr(1, 4'd1, 4'h1, 32'h000000CC);
    @(negedge clk);
    n_checks++;
    if (read_data !== {32'h22222222, 32'h111111CC}) begin n_errors++; $display("FAIL b2b_second: got %h expected 22222222111111cc", read_data); end
    next_cycle();
    clr_wr();
    @(negedge clk);
    n_checks++;
    if (read_data !== {32'h22222222, 32'h111111CC}) begin n_errors++; $display("FAIL b2b_final: got %h expected 22222222111111cc", read_data); end
  endtask

  task automatic test_clear_drop_reset();
    next_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("FAIL async_reset_ready: got %b expected 0", ready); end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    set_rd(0, 4'd2);
    set_rd(1, 4'd9);
    repeat (4) next_cycle();
    @(negedge clk);
    n_checks++;
    if (read_data !== {32'h12345678, 32'h00000000}) begin n_errors++; $display("FAIL clear_progress: got %h expected 1234567800000000", read_data); end
    next_cycle();
    set_wr(0, 4'd2, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    n_checks++;
    if (read_data[31:0] !== 32'h0) begin n_errors++; $display("FAIL no_bypass_in_clear: got %h expected 0", read_data[31:0]); end
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("FAIL ready_in_clear: got %b expected 0", ready); end
    next_cycle();
    clr_wr();
    @(negedge clk);
    n_checks++;
    if (read_data[31:0] !== 32'h0) begin n_errors++; $display("FAIL dropped_write: got %h expected 0", read_data[31:0]); end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin n_errors++; $display("FAIL restart_ready cycle %0d: got %b expected 0", i, ready); end
      if (i == 3) begin
        n_checks++;
        if (read_data[63:32] !== 32'h12345678) begin n_errors++; $display("FAIL restart_from_zero: got %h expected 12345678", read_data[63:32]); end
      end
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin n_errors++; $display("FAIL restart_ready_final: got %b expected 1", ready); end
    for (int a = 0; a < 16; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(15 - a));
      #1;
      n_checks++;
      if (read_data !== 64'h0) begin n_errors++; $display("FAIL recleared_read addr %0d: got %h expected 0", a, read_data); end
    end
  endtask

  initial begin
    test_reset();
    test_write_mask();
    test_same_entry();
    test_bypass();
    test_zero_mask();
    test_back_to_back();
    test_clear_drop_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/asic_latch_regfile.md
ASIC_LATCH_REGFILE -- requirements
Module: asic_latch_regfile

Interface
REQ-001 SHALL have parameters, one per line:
- CLOCK_INFO, 'b0, clock description passed to gating/register primitives
- TECHNOLOGY, STD_TECHNOLOGY_ASIC_TSMC, target for std_clock_gate
- DATA_WIDTH, 32, word width; multiple of LANE_WIDTH
- LANE_WIDTH, 8, bits per write-mask lane; LANES = DATA_WIDTH/LANE_WIDTH
- ADDR_WIDTH, 5, depth = 2**ADDR_WIDTH entries
- READ_PORTS, 2, combinational read ports
- WRITE_PORTS, 2, independent write ports
- BYPASS, 1, same-cycle write-to-read forwarding enable
- CLEAR_ON_RESET, 1, zero-fill sequence after reset
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- write_enable  in  WRITE_PORTS  per-port write request
- write_addr  in  WRITE_PORTS x ADDR_WIDTH  write address
- write_mask  in  WRITE_PORTS x LANES  per-lane write enable
- write_data  in  WRITE_PORTS x DATA_WIDTH  write data
- read_addr  in  READ_PORTS x ADDR_WIDTH  read address
- read_data  out  READ_PORTS x DATA_WIDTH  read data
- ready  out  1  array accepting writes

Function
REQ-003 SHALL store data in latches, one std_clock_gate per entry per lane; the gate enable is the OR over write ports of (enable && ready && mask lane && addr match).
REQ-004 SHALL register each port's write data, mask and address on the rising edge when that port's write_enable=1; the latch opens during the following high phase.
REQ-005 A write accepted at edge E SHALL appear on read_data combinationally in the cycle after E (1-cycle write latency).
REQ-006 Lanes with mask=0 SHALL retain prior contents; write_enable with all-zero mask SHALL change nothing.
REQ-007 When several ports write the same entry and lane at one edge, the highest-index port SHALL win, per lane.
REQ-008 read_data[i] SHALL equal entry[read_addr[i]] combinationally; any read port may alias any write or read port.
REQ-009 With BYPASS=1 and ready=1, a read in the same cycle as a matching write SHALL return write_data per masked lane, using REQ-007 priority; unmasked lanes come from storage. With BYPASS=0, stored data SHALL be returned.
REQ-010 Clear FSM states: CLEAR and READY. In CLEAR, a counter SHALL zero one entry per cycle (all lanes) from address 0 upward; after entry 2**ADDR_WIDTH-1 the FSM SHALL move to READY on the next edge.
REQ-011 ready SHALL be 0 in CLEAR and 1 in READY; writes presented while ready=0 SHALL be dropped silently, with no retry.
REQ-012 With CLEAR_ON_RESET=0 the FSM SHALL go to READY directly; latch contents after reset are undefined.
REQ-013 Clear-counter wrap: the counter SHALL be ADDR_WIDTH+1 bits wide, and the terminal condition SHALL be the MSB set, so there is no overflow aliasing at any depth.

Reset
REQ-014 rst=0 SHALL asynchronously force: FSM to CLEAR (or READY if CLEAR_ON_RESET=0), counter 0, ready 0 (or 1), and all sampled-write registers and enables to 0.
REQ-015 rst asserted mid-clear SHALL restart the clear from address 0 after deassertion.
REQ-016 read_data during and after reset SHALL follow latch contents; it is not forced.

Structure
REQ-017 Shared package asic_latch_pkg SHALL hold the clear-state enum (ASIC_LATCH_CLEAR, ASIC_LATCH_READY) and a function computing LANES.
REQ-018 Sub-module asic_latch_clear_fsm SHALL own the state, the counter and ready; the top level owns gates, latches, write registers and read muxes.
REQ-019 SHALL reuse std_clock_gate and std_register; no other primitives.

Verification (DATA_WIDTH=32, LANE_WIDTH=8, ADDR_WIDTH=4, READ_PORTS=2, WRITE_PORTS=2, BYPASS=1, CLEAR_ON_RESET=1)
REQ-020 Release reset -> ready=0 for 16 cycles then 1; read all 16 addresses -> 0x00000000.
REQ-021 Port0 writes addr 3 = 0xDEADBEEF, mask 0xF; next cycle read addr 3 -> 0xDEADBEEF; then port1 writes 0x11223344, mask 0x5 -> read 0xDE22BE44.
REQ-022 Both ports write addr 7 at the same edge (p0 0xAAAAAAAA mask 0xF, p1 0x55555555 mask 0x3) -> read addr 7 = 0xAAAA5555.
REQ-023 Bypass: port0 writes addr 9 = 0x12345678 while read_addr[0]=9 in the same cycle -> read_data[0]=0x12345678 before the edge.
REQ-024 Write attempted at clear cycle 5 -> dropped, entry stays 0; assert rst at clear cycle 8 and release -> clear restarts, ready after 16 more cycles.
